// File: rtl/avs_wait_gen.sv
// -----------------------------------------------------------------------------
// avs_wait_gen
//
// Generates Avalon-MM waitrequest timing for a simple register slave. A
// read or write seen in IDLE starts a transfer. The slave then holds off the
// master for a configurable number of wait cycles. It can optionally also wait
// for a backend ext_ready, bounded by a timeout. Finally it drops waitrequest
// for exactly one cycle (ACK).
//
// Handshake: the master's request is sampled only in IDLE. The transfer
// completes in the single cycle where avs_waitrequest is low. Requests that
// change while a transfer is in flight are ignored. A request still high in
// the cycle after ACK starts the next transfer.
//
// Parameters
//   C_CNT_W          width of the wait/timeout counter
//   C_RD_WAIT        extra wait cycles for a read
//   C_WR_WAIT        extra wait cycles for a write
//   C_USE_EXT_READY  1: completion also needs ext_ready (or a timeout)
//   C_TIMEOUT        cycles to wait for ext_ready after the minimum wait
//
// Ports
//   sys_clk          clock, rising edge
//   sys_rst          asynchronous active-high reset
//   avs_read         Avalon-MM read request
//   avs_write        Avalon-MM write request
//   ext_ready        backend completion (ignored when C_USE_EXT_READY=0)
//   avs_waitrequest  low for exactly one cycle per transfer
//   reg_rd_stb       one-cycle pulse in the first WAIT cycle of a read
//   reg_wr_stb       one-cycle pulse in the first WAIT cycle of a write
//   access_timeout   high during an ACK cycle reached by timeout
//   dbg_state        current FSM state (0 IDLE, 1 WAIT, 2 EXT, 3 ACK)
// -----------------------------------------------------------------------------
module avs_wait_gen #(
  parameter int C_CNT_W         = 4,
  parameter int C_RD_WAIT       = 0,
  parameter int C_WR_WAIT       = 0,
  parameter int C_USE_EXT_READY = 0,
  parameter int C_TIMEOUT       = 15
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       avs_read,
  input  logic       avs_write,
  input  logic       ext_ready,
  output logic       avs_waitrequest,
  output logic       reg_rd_stb,
  output logic       reg_wr_stb,
  output logic       access_timeout,
  output logic [1:0] dbg_state
);

  localparam int CNT_MAX = (1 << C_CNT_W) - 1;

  // Load values larger than the counter would silently truncate.
  if (C_RD_WAIT < 0 || C_RD_WAIT > CNT_MAX ||
      C_WR_WAIT < 0 || C_WR_WAIT > CNT_MAX ||
      C_TIMEOUT < 0 || C_TIMEOUT > CNT_MAX) begin : g_cfg_err
    $error("avs_wait_gen: wait/timeout parameter does not fit in C_CNT_W bits");
  end

  localparam logic [C_CNT_W-1:0] RD_LD = C_CNT_W'(C_RD_WAIT);
  localparam logic [C_CNT_W-1:0] WR_LD = C_CNT_W'(C_WR_WAIT);
  localparam logic [C_CNT_W-1:0] TO_LD = C_CNT_W'(C_TIMEOUT);
  localparam bit USE_EXT = (C_USE_EXT_READY != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXT  = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 wr_stb_q, wr_stb_d;
  logic                 tout_q, tout_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      tout_q   <= tout_d;
    end
  end

  // Strobe and timeout flags are computed one cycle ahead. They then land
  // in the first WAIT cycle and in the ACK cycle respectively.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    tout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (avs_read) begin
          // A read wins when both requests are high.
          state_d  = S_WAIT;
          cnt_d    = RD_LD;
          rd_stb_d = 1'b1;
        end else if (avs_write) begin
          state_d  = S_WAIT;
          cnt_d    = WR_LD;
          wr_stb_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (USE_EXT) begin
          state_d = S_EXT;
          cnt_d   = TO_LD;
        end else begin
          state_d = S_ACK;
        end
      end
      S_EXT: begin
        if (ext_ready) begin
          state_d = S_ACK;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Decoded purely from registered state: no input-to-output path.
  assign avs_waitrequest = (state_q != S_ACK);
  assign reg_rd_stb      = rd_stb_q;
  assign reg_wr_stb      = wr_stb_q;
  assign access_timeout  = tout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_avs_wait_gen.sv
// -----------------------------------------------------------------------------
// tb_avs_wait_gen
//
// Four instances with different parameter sets share clock and reset:
//   0: defaults
//   1: C_RD_WAIT=3, C_WR_WAIT=1
//   2: C_USE_EXT_READY=1, C_TIMEOUT=4
//   3: C_RD_WAIT=5
// Only one instance is active at a time. The driver pushes the expected
// strobe and ACK events, each tagged with instance and cycle number. A
// monitor on the falling edge pops and compares every strobe and every
// waitrequest-low cycle it sees.
// -----------------------------------------------------------------------------
module tb_avs_wait_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_v, wr_v;
  logic        er;
  logic [3:0]  wreq, rstb, wstb, tout;
  logic [1:0]  dbg0, dbg1, dbg2, dbg3;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // ack entry: {id[1:0], 1'b0, timeout, cycle[15:0]}
  // stb entry: {id[1:0], wr_stb, rd_stb, cycle[15:0]}
  logic [19:0] ack_q[$];
  logic [19:0] stb_q[$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avs_wait_gen u_def (
    .sys_clk(clk), .sys_rst(rst), .avs_read(rd_v[0]), .avs_write(wr_v[0]),
    .ext_ready(er), .avs_waitrequest(wreq[0]), .reg_rd_stb(rstb[0]),
    .reg_wr_stb(wstb[0]), .access_timeout(tout[0]), .dbg_state(dbg0));

  avs_wait_gen #(.C_RD_WAIT(3), .C_WR_WAIT(1)) u_rw (
    .sys_clk(clk), .sys_rst(rst), .avs_read(rd_v[1]), .avs_write(wr_v[1]),
    .ext_ready(er), .avs_waitrequest(wreq[1]), .reg_rd_stb(rstb[1]),
    .reg_wr_stb(wstb[1]), .access_timeout(tout[1]), .dbg_state(dbg1));

  avs_wait_gen #(.C_USE_EXT_READY(1), .C_TIMEOUT(4)) u_ext (
    .sys_clk(clk), .sys_rst(rst), .avs_read(rd_v[2]), .avs_write(wr_v[2]),
    .ext_ready(er), .avs_waitrequest(wreq[2]), .reg_rd_stb(rstb[2]),
    .reg_wr_stb(wstb[2]), .access_timeout(tout[2]), .dbg_state(dbg2));

  avs_wait_gen #(.C_RD_WAIT(5)) u_r5 (
    .sys_clk(clk), .sys_rst(rst), .avs_read(rd_v[3]), .avs_write(wr_v[3]),
    .ext_ready(er), .avs_waitrequest(wreq[3]), .reg_rd_stb(rstb[3]),
    .reg_wr_stb(wstb[3]), .access_timeout(tout[3]), .dbg_state(dbg3));

  // ---------------- helpers ----------------
  task automatic check_eq(input string name, input logic [19:0] act,
                          input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [19:0] mon_act;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (!wreq[i]) begin
          mon_act = {i[1:0], 1'b0, tout[i], cyc[15:0]};
          if (ack_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=%h required=none", mon_act);
          end else begin
            check_eq("ack", mon_act, ack_q.pop_front());
          end
        end else if (tout[i]) begin
          checks++;
          failures++;
          $display("FAIL timeout_outside_ack dut=%0d cycle=%0d actual=1 required=0", i, cyc);
        end
        if (rstb[i] || wstb[i]) begin
          mon_act = {i[1:0], wstb[i], rstb[i], cyc[15:0]};
          if (stb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_stb actual=%h required=none", mon_act);
          end else begin
            check_eq("stb", mon_act, stb_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One transfer on instance id. The request is raised now (cycle c). It
  // drops after 'hold' cycles. The ACK is expected at c+ack_off.
  // er_at >= 0 raises ext_ready at cycle c+er_at.
  task automatic xfer(input int id, input bit r, input bit w, input int hold,
                      input int ack_off, input bit to, input int er_at);
    int c;
    c = int'(cyc);
    rd_v[id] = r;
    wr_v[id] = w;
    stb_q.push_back({2'(id), (r ? 2'b01 : 2'b10), 16'(c + 1)});
    ack_q.push_back({2'(id), 1'b0, to, 16'(c + ack_off)});
    for (int k = 1; k <= ack_off; k++) begin
      tick();
      if (k == hold) begin
        rd_v[id] = 1'b0;
        wr_v[id] = 1'b0;
      end
      if (k == er_at) er = 1'b1;
    end
    er = 1'b0;
    rd_v[id] = 1'b0;
    wr_v[id] = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_waitrequest"}, {16'd0, wreq}, 20'h0000f);
    check_eq({name, "_strobes"}, {12'd0, rstb, wstb}, 20'h00000);
    check_eq({name, "_timeout"}, {16'd0, tout}, 20'h00000);
    check_eq({name, "_state"}, {12'd0, dbg3, dbg2, dbg1, dbg0}, 20'h00000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    rst  = 1'b1;
    rd_v = '0;
    wr_v = '0;
    er   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Defaults: read pulse, ACK in cycle 2.
    xfer(0, 1'b1, 1'b0, 1, 2, 1'b0, -1);
    // RD=3 read held: ACK in cycle 5; WR=1 write held: ACK in cycle 3.
    xfer(1, 1'b1, 1'b0, 5, 5, 1'b0, -1);
    xfer(1, 1'b0, 1'b1, 3, 3, 1'b0, -1);
    // Read dropped after one cycle still completes.
    xfer(1, 1'b1, 1'b0, 1, 5, 1'b0, -1);
    // Read and write together: read only, single ACK.
    xfer(0, 1'b1, 1'b1, 1, 2, 1'b0, -1);
    xfer(0, 1'b0, 1'b1, 1, 2, 1'b0, -1);
    // ext_ready never comes: timeout ACK in cycle 7.
    xfer(2, 1'b1, 1'b0, 1, 7, 1'b1, -1);
    // ext_ready in cycle 4: ACK in cycle 5, no timeout.
    xfer(2, 1'b1, 1'b0, 1, 5, 1'b0, 4);
    xfer(2, 1'b0, 1'b1, 1, 7, 1'b1, -1);

    // Read held for three back-to-back transfers: ACKs in cycles 2, 5, 8.
    c = int'(cyc);
    rd_v[0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      stb_q.push_back({2'd0, 2'b01, 16'(c + 1 + 3 * t)});
      ack_q.push_back({2'd0, 1'b0, 1'b0, 16'(c + 2 + 3 * t)});
    end
    repeat (8) tick();
    rd_v[0] = 1'b0;
    repeat (2) tick();

    // Reset in WAIT (RD=5): abandon the transfer with no ACK.
    c = int'(cyc);
    rd_v[3] = 1'b1;
    stb_q.push_back({2'd3, 2'b01, 16'(c + 1)});
    tick();
    rd_v[3] = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("after_reset");
    tick();
    // First read after release completes in 7 cycles.
    xfer(3, 1'b1, 1'b0, 1, 7, 1'b0, -1);
    repeat (4) tick();

    check_eq("ack_queue_empty", 20'(ack_q.size()), 20'd0);
    check_eq("stb_queue_empty", 20'(stb_q.size()), 20'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avs_wait_gen.md
AVS_WAIT_GEN -- requirements
Module: avs_wait_gen

Interface
REQ-001 C_CNT_W, default 4: width of the wait and timeout counters.
REQ-002 C_RD_WAIT, default 0: extra wait cycles inserted for a read.
REQ-003 C_WR_WAIT, default 0: extra wait cycles inserted for a write.
REQ-004 C_USE_EXT_READY, default 0: when 1, completion also requires ext_ready or a timeout.
REQ-005 C_TIMEOUT, default 15: cycles to wait for ext_ready after the minimum wait expires.
REQ-006 C_RD_WAIT, C_WR_WAIT and C_TIMEOUT SHALL each be no greater than 2^C_CNT_W-1; any other value is a configuration error.
REQ-007 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-008 sys_rst  in  1  asynchronous, active-high reset.
REQ-009 avs_read  in  1  Avalon-MM read request.
REQ-010 avs_write  in  1  Avalon-MM write request.
REQ-011 ext_ready  in  1  backend completion; ignored when C_USE_EXT_READY=0.
REQ-012 avs_waitrequest  out  1  Avalon-MM waitrequest; low for exactly one cycle per transfer.
REQ-013 reg_rd_stb  out  1  one-cycle pulse at read start.
REQ-014 reg_wr_stb  out  1  one-cycle pulse at write start.
REQ-015 access_timeout  out  1  one-cycle pulse when a transfer ends by timeout.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, EXT and ACK, held in registers.
REQ-017 IDLE: if avs_read|avs_write is high, go to WAIT and load the counter with C_RD_WAIT (read) or C_WR_WAIT (write).
REQ-018 If avs_read and avs_write are both high in IDLE, the transfer SHALL be a read (read priority).
REQ-019 reg_rd_stb / reg_wr_stb SHALL be registered, high in the first WAIT cycle only.
REQ-020 WAIT: counter !=0 -> decrement and stay.
REQ-021 WAIT: counter ==0 -> go to ACK if C_USE_EXT_READY=0; otherwise go to EXT and load the counter with C_TIMEOUT.
REQ-022 EXT: ext_ready=1 -> ACK.
REQ-023 EXT: counter ==0 with ext_ready=0 -> ACK with the timeout flag set.
REQ-024 EXT otherwise: decrement and stay.
REQ-025 ACK: unconditional transition to IDLE.
REQ-026 avs_waitrequest SHALL be low only in ACK, decoded from registered state only (no input-to-output combinational path).
REQ-027 access_timeout SHALL be high only during an ACK cycle entered via REQ-023.
REQ-028 Latency (C_USE_EXT_READY=0, request first high in cycle 0): avs_waitrequest low in cycle N+2, where N = C_RD_WAIT or C_WR_WAIT.
REQ-029 With N=0 this gives the legacy fixed two-cycle timing (low in cycle 2).
REQ-030 Request inputs SHALL be ignored outside IDLE.
REQ-031 A request dropped mid-transfer SHALL not abort it; the transfer completes normally.
REQ-032 A request held high in the cycle after ACK SHALL start a new transfer: back-to-back transfers, no idle gap beyond IDLE.
REQ-033 The counter SHALL never wrap: it loads only on entry to WAIT or EXT and decrements only while nonzero.

Reset
REQ-034 sys_rst asserted at any time SHALL immediately force state IDLE and counter 0.
REQ-035 During and after reset: avs_waitrequest=1, reg_rd_stb=0, reg_wr_stb=0, access_timeout=0.
REQ-036 Reset mid-transfer SHALL abandon the transfer with no ACK cycle.
REQ-037 The first request after reset release SHALL be handled as in REQ-017.

Verification
REQ-038 Defaults; avs_read pulsed in cycle 0 -> reg_rd_stb=1 in cycle 1; avs_waitrequest=0 only in cycle 2.
REQ-039 C_RD_WAIT=3, C_WR_WAIT=1; read held -> waitrequest low in cycle 5; then write held -> waitrequest low in cycle 3 of the write; reg_wr_stb pulsed once.
REQ-040 avs_read=avs_write=1 in the same cycle -> reg_rd_stb pulses, reg_wr_stb stays 0; exactly one ACK.
REQ-041 C_USE_EXT_READY=1, C_TIMEOUT=4, ext_ready=0 -> waitrequest low in cycle 7 with access_timeout=1; repeat with ext_ready=1 in cycle 4 -> ACK in cycle 5, access_timeout=0.
REQ-042 avs_read held continuously for 3 transfers (defaults) -> waitrequest low in cycles 2, 5, 8; three reg_rd_stb pulses.
REQ-043 sys_rst asserted in WAIT (C_RD_WAIT=5) -> outputs go to reset values immediately with no ACK; next read after release completes in 7 cycles.
